// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Number of bits needed to count 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a binary source and the BCD converter.
interface bin2bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 3
) ();

  logic                          start;
  logic [BIN_W-1:0]              bin_in;
  logic                          busy;
  logic                          done;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
  logic                          ovf;
  logic [DIGITS-1:0]             lz_mask;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ovf, lz_mask
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ovf, lz_mask
  );

endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout_c
);

  assign dout_c = (din >= BCD_DIGIT_W'(5)) ? din + BCD_DIGIT_W'(3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with overflow flag
// and leading-zero blanking mask.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  bin2bcd_seq_if.slave bus
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = clog2(BIN_W);
  localparam logic [DIGITS-1:0] LZ_RST = ~DIGITS'(1);

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [BIN_W-1:0]   shift_q, shift_nxt;
  logic [BCD_W-1:0]   work_q, work_nxt;
  logic               ovf_acc_q, ovf_acc_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic [BCD_W-1:0]   bcd_q, bcd_nxt;
  logic               ovf_q, ovf_nxt;
  logic [DIGITS-1:0]  lz_q, lz_nxt;

  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W-1:0]   work_sh;
  logic [BIN_W-1:0]   shift_sh;
  logic [DIGITS-1:0]  lz_sh;
  logic               zero_run;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .din    (work_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout_c (work_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The top bit of the corrected digits is lost by the shift: that is the overflow.
  assign work_sh  = {work_adj[BCD_W-2:0], shift_q[BIN_W-1]};
  assign shift_sh = {shift_q[BIN_W-2:0], 1'b0};

  // Bit i set when digit i and every digit above it are zero.
  always_comb begin
    lz_sh    = '0;
    zero_run = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run = zero_run & (work_sh[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      lz_sh[i] = zero_run;
    end
    lz_sh[0] = 1'b0;
  end

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    shift_nxt   = shift_q;
    work_nxt    = work_q;
    ovf_acc_nxt = ovf_acc_q;
    bcd_nxt     = bcd_q;
    ovf_nxt     = ovf_q;
    lz_nxt      = lz_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_nxt   = ST_SHIFT;
          shift_nxt   = bus.bin_in;
          work_nxt    = '0;
          ovf_acc_nxt = 1'b0;
          cnt_nxt     = CNT_W'(BIN_W - 1);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_nxt    = work_sh;
        shift_nxt   = shift_sh;
        ovf_acc_nxt = ovf_acc_q | work_adj[BCD_W-1];
        if (cnt_q == '0) begin
          state_nxt = ST_DONE;
          bcd_nxt   = work_sh;
          ovf_nxt   = ovf_acc_q | work_adj[BCD_W-1];
          lz_nxt    = lz_sh;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt == ST_SHIFT);
    done_nxt = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      work_q    <= '0;
      ovf_acc_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      lz_q      <= LZ_RST;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      shift_q   <= shift_nxt;
      work_q    <= work_nxt;
      ovf_acc_q <= ovf_acc_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      bcd_q     <= bcd_nxt;
      ovf_q     <= ovf_nxt;
      lz_q      <= lz_nxt;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
  assign bus.ovf     = ovf_q;
  assign bus.lz_mask = lz_q;

endmodule
